// File: rtl/nbody_pair_scheduler.sv
// Pair scheduler for one leapfrog velocity pass: issues every (i, j) body pair
// row-major, one per cycle, and tracks each result through a fixed-latency tag line.
module nbody_pair_scheduler #(
    parameter int BODIES   = 512,
    parameter int IDX_W    = $clog2(BODIES),
    parameter int PIPE_LAT = 122
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   num_bodies,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             issue_valid,
    output logic [IDX_W-1:0] issue_i,
    output logic [IDX_W-1:0] issue_j,
    output logic             issue_self,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_i,
    output logic [IDX_W-1:0] res_j,
    output logic             res_self,
    output logic             row_done,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: issue_* is a one-cycle presentation with no back-pressure; the
    // datapath must accept whenever issue_valid=1. stall only gates presentation.

    localparam int CNT_W = ($clog2(PIPE_LAT + 1) > IDX_W + 1) ? $clog2(PIPE_LAT + 1) : IDX_W + 1;
    localparam logic [IDX_W:0] MAX_N = (IDX_W + 1)'(BODIES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
        logic             is_self;
        logic             last;
    } tag_t;

    state_t           state;
    tag_t             pipe [PIPE_LAT];
    logic [IDX_W-1:0] ptr_i, ptr_j, last_idx;
    logic [CNT_W-1:0] in_flight, cnt_next;

    logic [IDX_W:0]   n_clamp;
    logic [IDX_W-1:0] n_last_new, cur_last, cur_i, cur_j, nxt_i, nxt_j;
    logic             final_pair, fire, accept_start;

    always_comb begin
        n_clamp      = (num_bodies > MAX_N) ? MAX_N : num_bodies;
        n_last_new   = IDX_W'(n_clamp - (IDX_W + 1)'(1));
        accept_start = (state == IDLE) && start && !abort;
        // In IDLE the first pair (0,0) is presented on the very edge that accepts start.
        cur_last     = (state == IDLE) ? n_last_new : last_idx;
        cur_i        = (state == IDLE) ? '0 : ptr_i;
        cur_j        = (state == IDLE) ? '0 : ptr_j;
        final_pair   = (cur_i == cur_last) && (cur_j == cur_last);
        nxt_j        = (cur_j == cur_last) ? '0 : cur_j + 1'b1;
        nxt_i        = (cur_j == cur_last) ? cur_i + 1'b1 : cur_i;
        fire         = !abort && ((accept_start && n_clamp != '0) ||
                                  (state == ISSUE && !stall));
        cnt_next     = in_flight + CNT_W'(issue_valid) - CNT_W'(res_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            issue_valid <= 1'b0;
            issue_i     <= '0;
            issue_j     <= '0;
            issue_self  <= 1'b0;
            ptr_i       <= '0;
            ptr_j       <= '0;
            last_idx    <= '0;
            in_flight   <= '0;
            for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
        end else if (abort && state != IDLE) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            issue_valid <= 1'b0;
            issue_i     <= '0;
            issue_j     <= '0;
            issue_self  <= 1'b0;
            ptr_i       <= '0;
            ptr_j       <= '0;
            in_flight   <= '0;
            for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{valid:   issue_valid,
                         i:       issue_i,
                         j:       issue_j,
                         is_self: issue_self,
                         last:    issue_valid && (issue_j == last_idx)};
            for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
            in_flight   <= cnt_next;
            issue_valid <= fire;
            issue_i     <= fire ? cur_i : '0;
            issue_j     <= fire ? cur_j : '0;
            issue_self  <= fire && (cur_i == cur_j);
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept_start) begin
                        last_idx <= n_last_new;
                        if (n_clamp == '0) begin
                            // Empty pass: go straight to the drain check without raising busy.
                            state <= DRAIN;
                        end else begin
                            busy  <= 1'b1;
                            state <= final_pair ? DRAIN : ISSUE;
                            ptr_i <= nxt_i;
                            ptr_j <= nxt_j;
                        end
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        if (final_pair) begin
                            state <= DRAIN;
                        end else begin
                            ptr_i <= nxt_i;
                            ptr_j <= nxt_j;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_next == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid = pipe[PIPE_LAT-1].valid;
    assign res_i     = pipe[PIPE_LAT-1].i;
    assign res_j     = pipe[PIPE_LAT-1].j;
    assign res_self  = pipe[PIPE_LAT-1].is_self;
    assign row_done  = pipe[PIPE_LAT-1].last;
    assign state_dbg = state;

endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Directed bench for nbody_pair_scheduler with PIPE_LAT=4 and a 16-body limit.
module tb_nbody_pair_scheduler;

    localparam int BODIES = 16;
    localparam int IDX_W  = 4;
    localparam int LAT    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W:0]   num_bodies = '0;
    logic             stall = 1'b0;
    logic             abort = 1'b0;
    logic             busy, issue_valid, issue_self, res_valid, res_self, row_done, done;
    logic [IDX_W-1:0] issue_i, issue_j, res_i, res_j;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    nbody_pair_scheduler #(.BODIES(BODIES), .IDX_W(IDX_W), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
        .stall(stall), .abort(abort), .busy(busy), .issue_valid(issue_valid),
        .issue_i(issue_i), .issue_j(issue_j), .issue_self(issue_self),
        .res_valid(res_valid), .res_i(res_i), .res_j(res_j), .res_self(res_self),
        .row_done(row_done), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " issue_valid"}, 32'(issue_valid), 0);
        chk({tag, " res_valid"}, 32'(res_valid), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " row_done"}, 32'(row_done), 0);
    endtask

    // Unstalled pass of n_eff bodies; optional start pulse with a different N mid-run.
    task automatic run_nominal(input int n_in, input int n_eff, input bit pulse_mid);
        int nn, tot, k, kr;
        bit iv, rv;
        string t;
        nn  = n_eff * n_eff;
        tot = nn + LAT + 1;
        num_bodies = (IDX_W + 1)'(n_in);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= tot + 1; c++) begin
            iv = (c <= nn);
            rv = (c >= LAT + 1) && (c <= LAT + nn);
            k  = c - 1;
            kr = c - LAT - 1;
            t  = $sformatf("n%0d c%0d", n_eff, c);
            chk({t, " issue_valid"}, 32'(issue_valid), 32'(iv));
            if (iv) begin
                chk({t, " issue_i"}, 32'(issue_i), k / n_eff);
                chk({t, " issue_j"}, 32'(issue_j), k % n_eff);
                chk({t, " issue_self"}, 32'(issue_self), 32'((k / n_eff) == (k % n_eff)));
            end
            chk({t, " res_valid"}, 32'(res_valid), 32'(rv));
            if (rv) begin
                chk({t, " res_i"}, 32'(res_i), kr / n_eff);
                chk({t, " res_j"}, 32'(res_j), kr % n_eff);
                chk({t, " res_self"}, 32'(res_self), 32'((kr / n_eff) == (kr % n_eff)));
            end
            chk({t, " row_done"}, 32'(row_done), 32'(rv && (kr % n_eff == n_eff - 1)));
            chk({t, " done"}, 32'(done), 32'(c == tot));
            chk({t, " busy"}, 32'(busy), 32'(c <= nn + LAT));
            if (pulse_mid && c == 2) begin
                start = 1'b1;
                num_bodies = 5'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    int iss_cyc [4] = '{1, 4, 5, 6};
    int res_cyc [4] = '{5, 8, 9, 10};

    initial begin
        // Reset state
        #3;
        chk_quiet("reset");
        chk("reset state", 32'(state_dbg), 0);
        step();
        rst = 1'b0;
        step();
        chk_quiet("post reset");

        // N=3, no stall
        run_nominal(3, 3, 1'b0);

        // N=2 with stall during cycles 2 and 3
        num_bodies = 5'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            int ik, rk;
            string t;
            ik = -1;
            rk = -1;
            for (int q = 0; q < 4; q++) begin
                if (iss_cyc[q] == c) ik = q;
                if (res_cyc[q] == c) rk = q;
            end
            t = $sformatf("stall c%0d", c);
            chk({t, " issue_valid"}, 32'(issue_valid), 32'(ik >= 0));
            if (ik >= 0) begin
                chk({t, " issue_i"}, 32'(issue_i), ik / 2);
                chk({t, " issue_j"}, 32'(issue_j), ik % 2);
            end
            chk({t, " res_valid"}, 32'(res_valid), 32'(rk >= 0));
            if (rk >= 0) begin
                chk({t, " res_i"}, 32'(res_i), rk / 2);
                chk({t, " res_j"}, 32'(res_j), rk % 2);
            end
            chk({t, " done"}, 32'(done), 32'(c == 11));
            chk({t, " busy"}, 32'(busy), 32'(c <= 10));
            stall = (c == 1 || c == 2);
            step();
        end
        stall = 1'b0;

        // N=0: done at cycle 2, busy never high
        num_bodies = 5'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("n0 c%0d issue_valid", c), 32'(issue_valid), 0);
            chk($sformatf("n0 c%0d busy", c), 32'(busy), 0);
            chk($sformatf("n0 c%0d done", c), 32'(done), 32'(c == 2));
            step();
        end

        // N=1: single self pair
        run_nominal(1, 1, 1'b0);

        // Abort and start together in IDLE: abort wins
        abort = 1'b1;
        start = 1'b1;
        num_bodies = 5'd3;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk_quiet("abort+start idle");
        step();
        chk_quiet("abort+start idle+1");

        // Abort during DRAIN with two results in flight
        num_bodies = 5'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("abort pre res_valid", 32'(res_valid), 1);
        chk("abort pre state", 32'(state_dbg), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_quiet("abort c7");
        chk("abort c7 state", 32'(state_dbg), 0);
        for (int c = 8; c <= 12; c++) begin
            chk_quiet($sformatf("abort c%0d", c));
            step();
        end
        run_nominal(2, 2, 1'b0);

        // Start pulse while busy with a different N is ignored
        run_nominal(3, 3, 1'b1);

        // Asynchronous reset mid-ISSUE
        num_bodies = 5'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre rst issue_valid", 32'(issue_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk_quiet("async rst");
        chk("async rst issue_i", 32'(issue_i), 0);
        chk("async rst state", 32'(state_dbg), 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_quiet($sformatf("rst release %0d", c));
            step();
        end

        // N above the limit clamps to 16: last pair (15,15)
        run_nominal(20, BODIES, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nbody_pair_scheduler.md
Name: nbody_pair_scheduler

Overview:
Sequences the gravitational-acceleration pipeline for one leapfrog velocity pass. It walks every (i, j) body pair and issues one pair per cycle to the RAM read ports and the fixed-latency acceleration datapath. A valid/tag delay line tracks each pair's result, and the block reports per-row completion and pass completion. It sits between the top-level state machine and the position/velocity memories plus the acceleration unit.

Parameters:
BODIES, 512, maximum body count supported
IDX_W, $clog2(BODIES), width of a body index
PIPE_LAT, 122, cycles from issue to result (2*AddTime + 5*MultTime + InvSqrtTime); minimum 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a pass; sampled only in IDLE
num_bodies  in  IDX_W+1  body count N (0..BODIES); latched on accepted start
stall  in  1  suppresses issue this cycle (RAM port conflict); results keep flowing
abort  in  1  cancels the pass and returns to IDLE
busy  out  1  high from the cycle after accepted start until the done cycle
issue_valid  out  1  a pair is presented this cycle
issue_i  out  IDX_W  target body index
issue_j  out  IDX_W  source body index
issue_self  out  1  issue_i == issue_j; datapath result must be discarded
res_valid  out  1  datapath output corresponds to a tracked pair
res_i  out  IDX_W  tag i of the result
res_j  out  IDX_W  tag j of the result
res_self  out  1  tag self flag
row_done  out  1  the last result for row res_i (res_j == N-1)
done  out  1  one-cycle pass-complete pulse

Behaviour:
- Reset: state=IDLE, all outputs 0, delay line cleared, in-flight counter 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> latch N. If N=0 -> DONE; else -> ISSUE with i=j=0. start while not IDLE is ignored.
- ISSUE, each cycle with stall=0:
  - Registered outputs present (i, j): issue_valid=1, issue_self=(i==j).
  - j increments. When j==N-1: j=0, i increments.
  - After pair (N-1, N-1) -> DRAIN.
  - The first pair appears at cycle t+1, where t is the start cycle. Pairs are row-major, exactly N*N of them, with no skips; self pairs are issued and flagged.
- ISSUE with stall=1: issue_valid=0, indices hold, no other effect.
- Delay line, PIPE_LAT deep, carries {valid, i, j, self}:
  - res_* equals the issue_* values from exactly PIPE_LAT cycles earlier. Bubbles propagate as res_valid=0.
  - row_done = res_valid & (res_j == N-1).
- In-flight counter (width >= IDX_W+1): +1 on issue_valid, -1 on res_valid, both on simultaneous events (net 0). It never exceeds PIPE_LAT.
- DRAIN: when in-flight reaches 0 (after the final res_valid) -> DONE.
- DONE: done=1 and busy=0 for one cycle -> IDLE.
- busy stays high through ISSUE and DRAIN, including stalled cycles.
- abort in ISSUE/DRAIN/DONE: next cycle state=IDLE, delay line and counter flushed, no done pulse, all res_* and issue_* outputs 0. abort in IDLE has no effect. If abort and start arrive together in IDLE, abort wins (start ignored).
- Async rst mid-pass: immediate return to reset values; no pulse on release.
- num_bodies > BODIES is clamped to BODIES at latch.
- Index arithmetic never wraps past N-1. i and j are compared against the latched N-1, never against BODIES.

Test Plan:
- PIPE_LAT=4, N=3, no stall -> 9 issues on consecutive cycles 1..9: (0,0)s,(0,1),(0,2),(1,0),(1,1)s,... Each res appears 4 cycles later. row_done at cycles 7, 10, 13. done at cycle 14. busy high cycles 1..13.
- PIPE_LAT=4, N=2, stall high on cycles 2-3 -> issues at cycles 1,4,5,6. res at 5,8,9,10. done at 11. In-flight peaks at 3.
- N=0 start -> no issue_valid, done at cycle 2, busy never high. N=1 -> single pair (0,0) with issue_self=1, res_self=1, row_done with it.
- abort during DRAIN with 2 results in flight -> res_valid=0 next cycle, no done, busy=0. A new start with N=2 then runs cleanly from (0,0).
- start pulsed while busy and num_bodies changed -> ignored; original N sequence completes unchanged.
- rst asserted asynchronously mid-ISSUE -> outputs 0 before the next clk edge. After deassertion, start N=BODIES: first pair (0,0), last pair (511,511), final row_done tag i=511.
